// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: decode constants used by the multi-cycle controller
// and the memory port sequencer state encoding.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE,
        ERR
    } mem_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles spent on one bus access and flags the cycle on which the
// access has used up its TIMEOUT budget.
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    // Saturates so a stuck enable can never wrap back to a small count.
    always_ff @(posedge clk) begin
        if (rst)
            count <= 8'd0;
        else if (clear)
            count <= 8'd0;
        else if (enable && count != 8'(TIMEOUT))
            count <= count + 8'd1;
    end

    // True during the TIMEOUT-th enabled cycle; completion that same cycle still wins.
    assign expired = enable && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_sequencer.sv
// Turns the multi-cycle controller's MemRead/MemWrite strobes into valid/ready bus
// accesses, owns the Instr/Data registers and stalls the controller until done.
module mem_port_sequencer
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    output logic              Stall,
    output logic [DATA_W-1:0] Instr,
    output logic [DATA_W-1:0] Data,
    output logic              BusErr,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata
);

    mem_state_t state, next;

    logic ir_q;
    logic access;
    logic start;
    logic capture;
    logic fail;
    logic fail_ir;
    logic cnt_en;
    logic expired;

    assign access = MemRead | MemWrite;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (start),
        .enable  (cnt_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next    = state;
        Stall   = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        fail    = 1'b0;
        fail_ir = ir_q;
        cnt_en  = 1'b0;
        case (state)
            IDLE: begin
                fail_ir = IRWrite;
                if (access) begin
                    Stall = 1'b1;
                    if (Adr[1:0] != 2'b00) begin
                        next = ERR;
                        fail = 1'b1;
                    end else begin
                        next  = REQ;
                        start = 1'b1;
                    end
                end
            end
            REQ: begin
                Stall  = 1'b1;
                cnt_en = 1'b1;
                // Completion beats an expiring counter in the same cycle.
                if (req_ready && (req_we || rsp_valid)) begin
                    next    = DONE;
                    capture = !req_we;
                end else if (expired) begin
                    next = ERR;
                    fail = 1'b1;
                end else if (req_ready) begin
                    next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                Stall  = 1'b1;
                cnt_en = 1'b1;
                if (rsp_valid) begin
                    next    = DONE;
                    capture = 1'b1;
                end else if (expired) begin
                    next = ERR;
                    fail = 1'b1;
                end
            end
            DONE:    next = IDLE;
            ERR:     next = IDLE;
            default: next = IDLE;
        endcase
    end

    assign req_valid = (state == REQ);

    // Access attributes are frozen at IDLE so the bus sees them stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            ir_q      <= 1'b0;
        end else if (state == IDLE && access) begin
            req_addr  <= Adr;
            req_wdata <= WriteData;
            req_we    <= MemWrite;
            ir_q      <= IRWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Instr  <= DATA_W'(NOP_INSTR);
            Data   <= '0;
            BusErr <= 1'b0;
        end else begin
            if (capture) begin
                Data <= rsp_rdata;
                if (ir_q)
                    Instr <= rsp_rdata;
            end
            if (fail) begin
                BusErr <= 1'b1;
                if (fail_ir)
                    Instr <= DATA_W'(NOP_INSTR);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench: directed vector table, randomized accesses against a
// transaction-level model, plus timeout and reset-during-wait sequences.
module tb_mem_port_sequencer;

    localparam int T = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Adr, WriteData;
    logic        MemRead, MemWrite, IRWrite;
    logic        Stall;
    logic [31:0] Instr, Data;
    logic        BusErr;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_sequencer #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .Adr(Adr), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .Stall(Stall), .Instr(Instr), .Data(Data), .BusErr(BusErr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, ir;
        logic [31:0] addr, wdata;
        int          d, r;
        logic [31:0] rdata;
        int          exp_stall;
        logic [31:0] exp_data, exp_instr;
        logic        exp_err, exp_req;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drives one controller access; the bus asserts req_ready d cycles into REQ
    // and, for reads, rsp_valid r cycles after that (r=0 means same cycle).
    task automatic run_access(input logic rd, input logic wr, input logic ir,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int d, input int r, input logic [31:0] rdata,
                              output int stalls, output logic bus_ok, output logic saw_req);
        int  k;
        bit  done;
        stalls = 0; bus_ok = 1'b1; saw_req = 1'b0; k = 0; done = 0;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; IRWrite = ir; Adr = addr; WriteData = wdata;
        while (!done && k < 64) begin
            req_ready = (k == 1 + d);
            rsp_valid = rd && !wr && (k == 1 + d + r);
            rsp_rdata = (k == 1 + d + r) ? rdata : $urandom;
            #1;
            if (req_valid) begin
                saw_req = 1'b1;
                if (req_addr !== addr || req_we !== wr || (wr && req_wdata !== wdata))
                    bus_ok = 1'b0;
            end
            if (Stall) stalls++;
            else done = 1;
            @(negedge clk);
            k++;
        end
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},     32'(Stall),     32'd0);
        check({tag, "_instr"},     Instr,          NOP);
        check({tag, "_data"},      Data,           32'd0);
        check({tag, "_buserr"},    32'(BusErr),    32'd0);
        check({tag, "_req_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_req_we"},    32'(req_we),    32'd0);
        check({tag, "_req_addr"},  req_addr,       32'd0);
        check({tag, "_req_wdata"}, req_wdata,      32'd0);
    endtask

    // Reference model state, updated per completed access.
    logic [31:0] m_data, m_instr;
    logic        m_err;

    initial begin
        int          stalls;
        logic        bus_ok, saw_req;
        int          exp_stall, n;
        logic        rd, wr, ir, mis;
        logic [31:0] addr, wdata, rdata;
        int          d, r;

        rst = 1'b1; Adr = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0;
        IRWrite = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;

        tbl[0] = '{1, 0, 1, 32'h0,  32'h0,        0, 1, 32'h00500093, 3, 32'h00500093, 32'h00500093, 0, 1};
        tbl[1] = '{0, 1, 0, 32'h40, 32'hDEADBEEF, 4, 0, 32'h0,        6, 32'h00500093, 32'h00500093, 0, 1};
        tbl[2] = '{1, 0, 0, 32'h44, 32'h0,        0, 0, 32'h12345678, 2, 32'h12345678, 32'h00500093, 0, 1};
        tbl[3] = '{1, 0, 0, 32'h42, 32'h0,        0, 0, 32'h0,        1, 32'h12345678, 32'h00500093, 1, 0};
        tbl[4] = '{1, 0, 1, 32'h48, 32'h0,        1, 2, 32'h00A00113, 5, 32'h00A00113, 32'h00A00113, 1, 1};

        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 5; i++) begin
            run_access(tbl[i].rd, tbl[i].wr, tbl[i].ir, tbl[i].addr, tbl[i].wdata,
                       tbl[i].d, tbl[i].r, tbl[i].rdata, stalls, bus_ok, saw_req);
            check($sformatf("vec%0d_stall_cycles", i), 32'(stalls),  32'(tbl[i].exp_stall));
            check($sformatf("vec%0d_data", i),         Data,         tbl[i].exp_data);
            check($sformatf("vec%0d_instr", i),        Instr,        tbl[i].exp_instr);
            check($sformatf("vec%0d_buserr", i),       32'(BusErr),  32'(tbl[i].exp_err));
            check($sformatf("vec%0d_req_seen", i),     32'(saw_req), 32'(tbl[i].exp_req));
            check($sformatf("vec%0d_req_stable", i),   32'(bus_ok),  32'd1);
        end

        // Randomized accesses against the transaction model.
        do_reset();
        m_data = 32'd0; m_instr = NOP; m_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            mis   = ($urandom_range(0, 7) == 0);
            wr    = ($urandom_range(0, 2) == 0);
            rd    = !wr;
            ir    = rd && $urandom_range(0, 1);
            addr  = {$urandom, 2'b00} & 32'h0000FFFC;
            if (mis) addr[1:0] = 2'($urandom_range(1, 3));
            wdata = $urandom; rdata = $urandom;
            d     = $urandom_range(0, 5);
            r     = $urandom_range(0, 4);

            if (mis) begin
                exp_stall = 1;
                m_err = 1'b1;
                if (ir) m_instr = NOP;
            end else begin
                n = d + 1 + (rd ? r : 0);
                if (n <= T) begin
                    exp_stall = 1 + n;
                    if (rd) begin
                        m_data = rdata;
                        if (ir) m_instr = rdata;
                    end
                end else begin
                    exp_stall = 1 + T;
                    m_err = 1'b1;
                    if (ir) m_instr = NOP;
                end
            end

            run_access(rd, wr, ir, addr, wdata, d, r, rdata, stalls, bus_ok, saw_req);
            check($sformatf("rnd%0d_stall_cycles", i), 32'(stalls),  32'(exp_stall));
            check($sformatf("rnd%0d_data", i),         Data,         m_data);
            check($sformatf("rnd%0d_instr", i),        Instr,        m_instr);
            check($sformatf("rnd%0d_buserr", i),       32'(BusErr),  32'(m_err));
            check($sformatf("rnd%0d_req_seen", i),     32'(saw_req), 32'(!mis));
            check($sformatf("rnd%0d_req_stable", i),   32'(bus_ok),  32'd1);
        end

        // Fetch whose response never arrives: IDLE cycle plus T bus cycles, then ERR.
        do_reset();
        run_access(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 0, 1000, 32'h0, stalls, bus_ok, saw_req);
        check("timeout_stall_cycles", 32'(stalls), 32'(1 + T));
        check("timeout_instr",        Instr,       NOP);
        check("timeout_buserr",       32'(BusErr), 32'd1);
        check("timeout_data",         Data,        32'd0);

        // Reset while waiting for a response; the late response must be ignored.
        @(negedge clk);
        MemRead = 1'b1; IRWrite = 1'b1; Adr = 32'h50;
        @(negedge clk);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #1;
        check("rstwait_stalled", 32'(Stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; MemRead = 1'b0; IRWrite = 1'b0;
        rsp_valid = 1'b1; rsp_rdata = 32'hCAFEF00D;
        #1;
        check_reset_outputs("rstwait");
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        check("late_rsp_data",  Data,         32'd0);
        check("late_rsp_instr", Instr,        NOP);
        check("late_rsp_stall", 32'(Stall),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

endmodule
